// File: rtl/song_sequencer.sv
// Song sequencer: walks {note, duration} entries of a synchronous song ROM and
// hands each note to a note player, with pause, loop and live song change.
module song_sequencer #(
   parameter int unsigned SONG_W      = 2,
   parameter int unsigned IDX_W       = 5,
   parameter int unsigned NOTE_W      = 6,
   parameter int unsigned DUR_W       = 6,
   parameter int unsigned END_ON_ZERO = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     play,
   input  logic                     loop,
   input  logic [SONG_W-1:0]        song,
   input  logic                     note_done,
   output logic [SONG_W+IDX_W-1:0]  rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]  rom_data,
   output logic [NOTE_W-1:0]        note,
   output logic [DUR_W-1:0]         duration,
   output logic                     new_note,
   output logic                     song_done,
   output logic [IDX_W-1:0]         note_index,
   output logic                     busy
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_PLAY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   logic [2:0]        state,    state_n;
   logic [SONG_W-1:0] song_q,   song_q_n;
   logic [IDX_W-1:0]  index,    index_n;
   logic              stale,    stale_n;
   logic [NOTE_W-1:0] note_n;
   logic [DUR_W-1:0]  duration_n;
   logic              new_note_n;
   logic              song_done_n;
   logic              end_path;
   logic              active;

   logic [NOTE_W-1:0] rom_note;
   logic [DUR_W-1:0]  rom_dur;
   logic              end_mark;

   assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];
   assign end_mark = (END_ON_ZERO != 0) && (rom_dur == '0);
   assign active   = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_PLAY);

   always_comb begin
      state_n     = state;
      song_q_n    = song_q;
      index_n     = index;
      stale_n     = stale;
      note_n      = note;
      duration_n  = duration;
      new_note_n  = 1'b0;
      song_done_n = 1'b0;
      end_path    = 1'b0;

      case (state)
         ST_IDLE: begin
            index_n = '0;
            if (play) begin
               song_q_n = song;
               state_n  = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (play) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            // A pause in LOAD marks the ROM word stale so the access is reissued via FETCH.
            if (!play) begin
               stale_n = 1'b1;
            end else if (stale) begin
               stale_n = 1'b0;
               state_n = ST_FETCH;
            end else if (end_mark) begin
               end_path = 1'b1;
            end else begin
               note_n     = rom_note;
               duration_n = rom_dur;
               new_note_n = 1'b1;
               state_n    = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (play && note_done) begin
               if (index == IDX_LAST) begin
                  end_path = 1'b1;
               end else begin
                  index_n = index + 1'b1;
                  state_n = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            if (!play) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      if (end_path) begin
         song_done_n = 1'b1;
         index_n     = '0;
         if (loop) begin
            song_q_n = song;
            state_n  = ST_FETCH;
         end else begin
            state_n  = ST_DONE;
         end
      end

      // Song change overrides everything decided above, including end-of-song.
      if (active && play && (song != song_q)) begin
         state_n     = ST_FETCH;
         song_q_n    = song;
         index_n     = '0;
         stale_n     = 1'b0;
         note_n      = note;
         duration_n  = duration;
         new_note_n  = 1'b0;
         song_done_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         song_q    <= '0;
         index     <= '0;
         stale     <= 1'b0;
         note      <= '0;
         duration  <= '0;
         new_note  <= 1'b0;
         song_done <= 1'b0;
         busy      <= 1'b0;
         rom_addr  <= '0;
      end else begin
         state     <= state_n;
         song_q    <= song_q_n;
         index     <= index_n;
         stale     <= stale_n;
         note      <= note_n;
         duration  <= duration_n;
         new_note  <= new_note_n;
         song_done <= song_done_n;
         busy      <= (state_n == ST_FETCH) || (state_n == ST_LOAD) || (state_n == ST_PLAY);
         rom_addr  <= {song_q_n, index_n};
      end
   end

   assign note_index = index;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a synchronous ROM model and an
// optional note player that pulses note_done four cycles after each new_note.
module tb_song_sequencer;

   logic        clk;
   logic        reset_n;
   logic        play;
   logic        loop;
   logic [1:0]  song;
   logic        note_done;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note;
   logic [5:0]  duration;
   logic        new_note;
   logic        song_done;
   logic [4:0]  note_index;
   logic        busy;

   song_sequencer #(
      .SONG_W(2), .IDX_W(5), .NOTE_W(6), .DUR_W(6), .END_ON_ZERO(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .play(play), .loop(loop), .song(song),
      .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
      .note(note), .duration(duration), .new_note(new_note),
      .song_done(song_done), .note_index(note_index), .busy(busy)
   );

   logic [11:0] rom_mem [0:127];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, nn_count = 0, sd_count = 0, nn_cyc = 0, sd_cyc = 0;
   int both_err = 0, nd_cnt = 0, sd_before = 0;
   bit auto_nd = 1'b0;
   logic [4:0] idx_q  [$];
   logic [6:0] addr_q [$];
   logic [5:0] note_q [$];
   logic [5:0] dur_q  [$];

   function automatic logic [5:0] note_of(int s, int i);
      return 6'((s * 16 + i) % 64);
   endfunction

   function automatic logic [5:0] dur_of(int s, int i);
      if (s == 0 && i >= 4) return 6'd0;
      if (s == 2 && i == 3) return 6'd0;
      return 6'(i + 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      note_done = 1'b0;
      if (new_note && song_done) both_err++;
      if (song_done) begin
         sd_count++;
         sd_cyc = cyc;
      end
      if (new_note) begin
         nn_count++;
         nn_cyc = cyc;
         idx_q.push_back(note_index);
         addr_q.push_back(rom_addr);
         note_q.push_back(note);
         dur_q.push_back(duration);
         nd_cnt = 4;
      end else if (nd_cnt > 0) begin
         nd_cnt--;
         if (nd_cnt == 0 && auto_nd) note_done = 1'b1;
      end
   endtask

   task automatic clear_log();
      nn_count = 0;
      sd_count = 0;
      idx_q.delete();
      addr_q.delete();
      note_q.delete();
      dur_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; play = 1'b0; loop = 1'b0; song = 2'd0; note_done = 1'b0;
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 32; i++)
            rom_mem[s * 32 + i] = {note_of(s, i), dur_of(s, i)};

      #12;
      check("rst_note", note, 0);
      check("rst_duration", duration, 0);
      check("rst_new_note", new_note, 0);
      check("rst_song_done", song_done, 0);
      check("rst_busy", busy, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_note_index", note_index, 0);
      #10 reset_n = 1'b1;
      tick(); tick();
      check("idle_busy", busy, 0);

      // Full 32-note song, latency from play
      song = 2'd1; play = 1'b1; auto_nd = 1'b1;
      tick();
      check("lat_fetch_busy", busy, 1);
      check("lat_fetch_addr", rom_addr, 7'h20);
      tick();
      check("lat_edge2_new_note", new_note, 0);
      tick();
      check("lat_edge3_new_note", new_note, 1);
      for (int c = 0; c < 800 && sd_count == 0; c++) tick();
      check("s1_song_done_seen", sd_count, 1);
      check("s1_sd_gap", sd_cyc - nn_cyc, 5);
      for (int c = 0; c < 10; c++) tick();
      check("s1_nn_count", nn_count, 32);
      check("s1_sd_count", sd_count, 1);
      check("s1_done_busy", busy, 0);
      check("s1_done_note", note, 47);
      check("s1_done_dur", duration, 32);
      check("s1_done_index", note_index, 0);
      for (int k = 0; k < 32 && k < addr_q.size(); k++) begin
         check($sformatf("s1_addr%0d", k), addr_q[k], 7'h20 + k);
         check($sformatf("s1_note%0d", k), note_q[k], note_of(1, k));
      end
      play = 1'b0;
      tick();

      // Song 2 ends at index 3 via zero duration
      clear_log();
      song = 2'd2; play = 1'b1;
      for (int c = 0; c < 300 && sd_count == 0; c++) tick();
      for (int c = 0; c < 20; c++) tick();
      check("s2_nn_count", nn_count, 3);
      check("s2_sd_count", sd_count, 1);
      check("s2_sd_gap", sd_cyc - nn_cyc, 7);
      check("s2_busy", busy, 0);
      for (int k = 0; k < 3 && k < idx_q.size(); k++) begin
         check($sformatf("s2_idx%0d", k), idx_q[k], k);
         check($sformatf("s2_dur%0d", k), dur_q[k], k + 1);
      end
      play = 1'b0;
      tick();

      // Looping 4-note song
      clear_log();
      song = 2'd0; loop = 1'b1; play = 1'b1;
      for (int c = 0; c < 300 && sd_count < 2; c++) tick();
      check("loop_nn_count", nn_count, 8);
      check("loop_busy", busy, 1);
      for (int k = 0; k < 8 && k < idx_q.size(); k++)
         check($sformatf("loop_idx%0d", k), idx_q[k], k % 4);
      loop = 1'b0;
      for (int c = 0; c < 300 && sd_count < 3; c++) tick();
      tick(); tick();
      check("loop_end_nn", nn_count, 12);
      check("loop_end_busy", busy, 0);
      play = 1'b0;
      tick();

      // Pause in PLAY with note_done during the pause
      clear_log();
      song = 2'd1; play = 1'b1; auto_nd = 1'b1;
      for (int c = 0; c < 100 && nn_count < 3; c++) tick();
      auto_nd = 1'b0;
      play = 1'b0;
      tick(); tick(); tick();
      note_done = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      check("pause_index", note_index, 2);
      check("pause_nn", nn_count, 3);
      check("pause_busy", busy, 1);
      check("pause_note", note, note_of(1, 2));
      check("pause_addr", rom_addr, 7'h22);
      play = 1'b1;
      tick(); tick();
      check("resume_index_hold", note_index, 2);
      check("resume_nn_hold", nn_count, 3);
      note_done = 1'b1;
      tick();
      check("resume_index_adv", note_index, 3);
      check("resume_addr", rom_addr, 7'h23);
      tick(); tick();
      check("resume_new_note", new_note, 1);
      check("resume_nn", nn_count, 4);
      check("resume_note", note, note_of(1, 3));

      // Song change 1 -> 3 at index 7
      auto_nd = 1'b1;
      for (int c = 0; c < 200 && !(new_note && note_index == 5'd7); c++) tick();
      check("chg_at_idx7", note_index, 7);
      auto_nd = 1'b0;
      sd_before = sd_count;
      song = 2'd3;
      tick();
      check("chg_fetch_index", note_index, 0);
      check("chg_fetch_sd", song_done, 0);
      tick(); tick();
      check("chg_new_note", new_note, 1);
      check("chg_addr", rom_addr, 7'h60);
      check("chg_index", note_index, 0);
      check("chg_note", note, note_of(3, 0));
      check("chg_no_sd", sd_count, sd_before);

      // Asynchronous reset mid-song
      reset_n = 1'b0;
      #1;
      check("areset_new_note", new_note, 0);
      check("areset_busy", busy, 0);
      check("areset_note", note, 0);
      check("areset_duration", duration, 0);
      check("areset_addr", rom_addr, 0);
      check("areset_index", note_index, 0);
      check("areset_song_done", song_done, 0);
      play = 1'b0;
      sd_before = sd_count;
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_no_sd", sd_count, sd_before);
      song = 2'd2; play = 1'b1;
      tick(); tick();
      check("post_rst_edge2", new_note, 0);
      tick();
      check("post_rst_new_note", new_note, 1);
      check("post_rst_index", note_index, 0);
      check("post_rst_addr", rom_addr, 7'h40);
      check("post_rst_note", note, note_of(2, 0));
      check("post_rst_dur", duration, 1);

      check("nn_sd_exclusive", both_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
